// File: rtl/ibus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ibus_initiator
// Description : IBUS bus master; turns single CPU load/store requests into one
//               IBUS transaction each, with busy-timeout and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_initiator #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DI,
    input  logic [1:0]  CPU_SZ,
    input  logic        CPU_WE,
    input  logic        CPU_SX,
    input  logic        CPU_REQ,
    output logic        CPU_ACK,
    output logic        CPU_ERR,
    output logic [31:0] CPU_DO,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    sz_q, sz_d;
    logic          sx_q, sx_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_err_q, cpu_err_d;
    logic [31:0]   cpu_do_q, cpu_do_d;
    logic [31:0]   ibus_a_q, ibus_a_d;
    logic [31:0]   ibus_do_q, ibus_do_d;
    logic [3:0]    ibus_ba_q, ibus_ba_d;
    logic          ibus_we_q, ibus_we_d;
    logic          ibus_req_q, ibus_req_d;

    logic          w_illegal;
    logic [3:0]    w_ba;
    logic [31:0]   w_wdata;
    logic [7:0]    w_rd_byte;
    logic [15:0]   w_rd_word;
    logic [31:0]   w_rd_ext;

    // Request decode: lane enables and replicated store data
    always_comb begin
        w_illegal = 1'b0;
        w_ba      = 4'b1111;
        w_wdata   = CPU_DI;
        case (CPU_SZ)
            2'b00: begin
                w_ba    = 4'b1000 >> CPU_A[1:0];
                w_wdata = {4{CPU_DI[7:0]}};
            end
            2'b01: begin
                w_illegal = CPU_A[0];
                w_ba      = CPU_A[1] ? 4'b0011 : 4'b1100;
                w_wdata   = {2{CPU_DI[15:0]}};
            end
            2'b10:   w_illegal = (CPU_A[1:0] != 2'b00);
            default: w_illegal = 1'b1;
        endcase
        if (!CPU_WE) begin
            w_wdata = 32'h0;
        end
    end

    // Read lane extraction from the latched address (big-endian lanes)
    always_comb begin
        case (ibus_a_q[1:0])
            2'b00:   w_rd_byte = IBUS_DI[31:24];
            2'b01:   w_rd_byte = IBUS_DI[23:16];
            2'b10:   w_rd_byte = IBUS_DI[15:8];
            default: w_rd_byte = IBUS_DI[7:0];
        endcase
        w_rd_word = ibus_a_q[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
        case (sz_q)
            2'b00:   w_rd_ext = {{24{sx_q & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_rd_ext = {{16{sx_q & w_rd_word[15]}}, w_rd_word};
            default: w_rd_ext = IBUS_DI;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sz_d       = sz_q;
        sx_d       = sx_q;
        cpu_ack_d  = cpu_ack_q;
        cpu_err_d  = cpu_err_q;
        cpu_do_d   = cpu_do_q;
        ibus_a_d   = ibus_a_q;
        ibus_do_d  = ibus_do_q;
        ibus_ba_d  = ibus_ba_q;
        ibus_we_d  = ibus_we_q;
        ibus_req_d = ibus_req_q;
        if (CE_R) begin
            cpu_ack_d = 1'b0;
            cpu_err_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CPU_REQ && !cpu_ack_q) begin
                        if (w_illegal) begin
                            cpu_ack_d = 1'b1;
                            cpu_err_d = 1'b1;
                            cpu_do_d  = 32'h0;
                        end else begin
                            ibus_a_d   = CPU_A;
                            ibus_we_d  = CPU_WE;
                            ibus_req_d = 1'b1;
                            ibus_ba_d  = w_ba;
                            ibus_do_d  = w_wdata;
                            sz_d       = CPU_SZ;
                            sx_d       = CPU_SX;
                            timer_d    = '0;
                            state_d    = S_BUS;
                        end
                    end
                end
                default: begin
                    if (!IBUS_ACT || (IBUS_BUSY && TIMEOUT != 0 && timer_q == TO_LAST)) begin
                        cpu_ack_d  = 1'b1;
                        cpu_err_d  = 1'b1;
                        cpu_do_d   = 32'h0;
                        ibus_req_d = 1'b0;
                        ibus_we_d  = 1'b0;
                        state_d    = S_IDLE;
                    end else if (IBUS_BUSY) begin
                        timer_d = timer_q + 1'b1;
                    end else begin
                        cpu_ack_d  = 1'b1;
                        ibus_req_d = 1'b0;
                        ibus_we_d  = 1'b0;
                        state_d    = S_IDLE;
                        // Stores leave the previous load result in place
                        if (!ibus_we_q) begin
                            cpu_do_d = w_rd_ext;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            sz_q       <= 2'b00;
            sx_q       <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_err_q  <= 1'b0;
            cpu_do_q   <= 32'h0;
            ibus_a_q   <= 32'h0;
            ibus_do_q  <= 32'h0;
            ibus_ba_q  <= 4'h0;
            ibus_we_q  <= 1'b0;
            ibus_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sz_q       <= sz_d;
            sx_q       <= sx_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_err_q  <= cpu_err_d;
            cpu_do_q   <= cpu_do_d;
            ibus_a_q   <= ibus_a_d;
            ibus_do_q  <= ibus_do_d;
            ibus_ba_q  <= ibus_ba_d;
            ibus_we_q  <= ibus_we_d;
            ibus_req_q <= ibus_req_d;
        end
    end

    assign CPU_ACK  = cpu_ack_q;
    assign CPU_ERR  = cpu_err_q;
    assign CPU_DO   = cpu_do_q;
    assign IBUS_A   = ibus_a_q;
    assign IBUS_DO  = ibus_do_q;
    assign IBUS_BA  = ibus_ba_q;
    assign IBUS_WE  = ibus_we_q;
    assign IBUS_REQ = ibus_req_q;

endmodule
`default_nettype wire

// File: tb/tb_ibus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibus_initiator
// Description : Self-checking bench for ibus_initiator against a request-level
//               reference model (directed plan items plus random requests).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibus_initiator;

    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R;
    logic [31:0] CPU_A, CPU_DI, IBUS_DI;
    logic [1:0]  CPU_SZ;
    logic        CPU_WE, CPU_SX, CPU_REQ, IBUS_BUSY, IBUS_ACT;
    logic        CPU_ACK, CPU_ERR, IBUS_WE, IBUS_REQ;
    logic [31:0] CPU_DO, IBUS_A, IBUS_DO;
    logic [3:0]  IBUS_BA;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_do = 32'h0;

    ibus_initiator #(.TIMEOUT(TO), .TW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
        .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_SZ(CPU_SZ), .CPU_WE(CPU_WE),
        .CPU_SX(CPU_SX), .CPU_REQ(CPU_REQ), .CPU_ACK(CPU_ACK), .CPU_ERR(CPU_ERR),
        .CPU_DO(CPU_DO), .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_DI(IBUS_DI),
        .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
        .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: lane/size rules expressed arithmetically
    function automatic bit m_legal(input logic [31:0] a, input logic [1:0] sz);
        int unsigned al;
        al = 1 << sz;
        return (sz != 2'b11) && ((a % al) == 0);
    endfunction

    function automatic logic [3:0] m_ba(input logic [31:0] a, input logic [1:0] sz);
        int unsigned bytes, first;
        logic [3:0]  ba;
        bytes = 1 << sz;
        first = a % 4;
        ba = 4'h0;
        for (int i = 0; i < 4; i++)
            if (i >= first && i < first + bytes) ba[3 - i] = 1'b1;
        return ba;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return (d % 256) * 32'h0101_0101;
        if (sz == 2'b01) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sx, input logic [31:0] rd);
        longint unsigned bits, v;
        bits = 64'd8 << sz;
        if (sz == 2'b10) return rd;
        v = (rd >> ((4 - (a % 4) - (1 << sz)) * 8)) % (64'd1 << bits);
        if (sx && v >= (64'd1 << (bits - 1))) v = v + 64'h1_0000_0000 - (64'd1 << bits);
        return v[31:0];
    endfunction

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic we,
                           input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                           input int nbusy, input logic act);
        int left, nb;
        bit fin;
        CPU_A = a; CPU_SZ = sz; CPU_WE = we; CPU_SX = sx; CPU_DI = wd; CPU_REQ = 1'b1;
        IBUS_ACT = act; IBUS_BUSY = (nbusy > 0); IBUS_DI = rd;
        edge1();
        if (!m_legal(a, sz)) begin
            exp_do = 32'h0;
            chk("bad_ack", CPU_ACK, 1); chk("bad_err", CPU_ERR, 1);
            chk("bad_do", CPU_DO, exp_do); chk("bad_req", IBUS_REQ, 0);
            CPU_REQ = 1'b0;
            edge1();
            chk("bad_ack_clr", CPU_ACK, 0); chk("bad_req2", IBUS_REQ, 0);
            return;
        end
        chk("req", IBUS_REQ, 1); chk("addr", IBUS_A, a); chk("we", IBUS_WE, we);
        chk("ba", IBUS_BA, m_ba(a, sz)); chk("wdata", IBUS_DO, we ? m_wdata(sz, wd) : 32'h0);
        chk("ack_early", CPU_ACK, 0);
        CPU_REQ = 1'b0; CPU_A = ~a; CPU_DI = ~wd; CPU_SZ = ~sz; CPU_SX = ~sx;
        left = nbusy; nb = 0; fin = 0;
        for (int e = 0; e < 40 && !fin; e++) begin
            edge1();
            if (!act || (left > 0 && nb + 1 == TO)) begin
                exp_do = 32'h0;
                chk("err_ack", CPU_ACK, 1); chk("err_err", CPU_ERR, 1);
                chk("err_do", CPU_DO, exp_do); chk("err_req", IBUS_REQ, 0);
                chk("err_we", IBUS_WE, 0);
                fin = 1;
            end else if (left > 0) begin
                left--; nb++;
                chk("busy_req", IBUS_REQ, 1); chk("busy_ack", CPU_ACK, 0);
                IBUS_BUSY = (left > 0);
            end else begin
                if (!we) exp_do = m_read(a, sz, sx, rd);
                chk("ok_ack", CPU_ACK, 1); chk("ok_err", CPU_ERR, 0);
                chk("ok_do", CPU_DO, exp_do); chk("ok_req", IBUS_REQ, 0);
                fin = 1;
            end
        end
        if (!fin) chk("no_completion", 0, 1);
        IBUS_BUSY = 1'b0;
        edge1();
        chk("ack_clr", CPU_ACK, 0); chk("err_clr", CPU_ERR, 0);
        chk("do_hold", CPU_DO, exp_do); chk("ba_hold", IBUS_BA, m_ba(a, sz));
        chk("a_hold", IBUS_A, a);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rsz;
        int          rb;
        RST_N = 1'b0; CE_R = 1'b1; CPU_A = '0; CPU_DI = '0; CPU_SZ = '0; CPU_WE = 0;
        CPU_SX = 0; CPU_REQ = 0; IBUS_DI = '0; IBUS_BUSY = 0; IBUS_ACT = 1;
        edge1(); edge1();
        chk("rst_ack", CPU_ACK, 0); chk("rst_err", CPU_ERR, 0); chk("rst_do", CPU_DO, 0);
        chk("rst_a", IBUS_A, 0); chk("rst_wdo", IBUS_DO, 0); chk("rst_ba", IBUS_BA, 0);
        chk("rst_we", IBUS_WE, 0); chk("rst_req", IBUS_REQ, 0);
        RST_N = 1'b1;
        edge1();

        run_txn(32'hFFFF_FF04, 2'b10, 0, 0, 32'h0, 32'h1234_5678, 0, 1);
        run_txn(32'hFFFF_FF03, 2'b00, 0, 1, 32'h0, 32'h0000_00F0, 0, 1);
        run_txn(32'hFFFF_FF03, 2'b00, 0, 0, 32'h0, 32'h0000_00F0, 0, 1);
        run_txn(32'hFFFF_FF02, 2'b01, 0, 1, 32'h0, 32'h0000_ABCD, 0, 1);
        run_txn(32'hFFFF_FF0E, 2'b01, 1, 0, 32'h0000_ABCD, 32'h0, 0, 1);
        run_txn(32'hFFFF_FF01, 2'b00, 1, 0, 32'h0000_005A, 32'h0, 0, 1);
        run_txn(32'hFFFF_FF02, 2'b10, 0, 0, 32'h0, 32'h0, 0, 1);
        run_txn(32'hFFFF_FF00, 2'b11, 0, 0, 32'h0, 32'h0, 0, 1);
        run_txn(32'hFFFF_FF08, 2'b10, 0, 0, 32'h0, 32'hCAFE_F00D, 3, 1);
        run_txn(32'hFFFF_FF08, 2'b10, 0, 0, 32'h0, 32'hCAFE_F00D, 20, 1);
        run_txn(32'hFFFF_FF08, 2'b10, 1, 0, 32'h1111_2222, 32'h0, 0, 0);

        // Reset while the responder holds the bus busy
        CPU_A = 32'hFFFF_FF10; CPU_SZ = 2'b10; CPU_WE = 0; CPU_REQ = 1; IBUS_BUSY = 1; IBUS_ACT = 1;
        edge1();
        chk("mr_req", IBUS_REQ, 1);
        CPU_REQ = 0; RST_N = 1'b0;
        edge1();
        RST_N = 1'b1; exp_do = 32'h0;
        chk("mr_req_clr", IBUS_REQ, 0); chk("mr_ack", CPU_ACK, 0);
        edge1();
        chk("mr_ack2", CPU_ACK, 0); chk("mr_req2", IBUS_REQ, 0);
        IBUS_BUSY = 0;
        run_txn(32'hFFFF_FF10, 2'b10, 0, 0, 32'h0, 32'h8765_4321, 0, 1);

        // Clock-enable held low mid-transaction freezes everything
        CPU_A = 32'hFFFF_FF21; CPU_SZ = 2'b00; CPU_WE = 1; CPU_DI = 32'h77; CPU_REQ = 1;
        edge1();
        chk("ce_req", IBUS_REQ, 1);
        CPU_REQ = 0; CE_R = 0;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("ce_frz_req", IBUS_REQ, 1); chk("ce_frz_ack", CPU_ACK, 0);
            chk("ce_frz_do", IBUS_DO, 32'h7777_7777);
        end
        CE_R = 1;
        edge1();
        chk("ce_ack", CPU_ACK, 1); chk("ce_err", CPU_ERR, 0); chk("ce_req_clr", IBUS_REQ, 0);
        edge1();

        for (int t = 0; t < 60; t++) begin
            ra  = 32'hFFFF_FF00 | ($urandom % 256);
            rsz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rsz) - 1);
            rb = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3));
            run_txn(ra, rsz, 1'($urandom), 1'($urandom), $urandom, $urandom, rb,
                    $urandom_range(0, 9) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
